// File: rtl/rotate_tetromino_unit.sv
// Single-stage tetromino rotator: registers the rotated piece with cells looked
// up from a fixed SRS shape table; unknown pieces pass through unrotated.
`ifndef GLOBAL_SV
`define GLOBAL_SV
`define TETROMINO_I_IDX 3'd0
`define TETROMINO_O_IDX 3'd1
`define TETROMINO_T_IDX 3'd2
`define TETROMINO_S_IDX 3'd3
`define TETROMINO_Z_IDX 3'd4
`define TETROMINO_J_IDX 3'd5
`define TETROMINO_L_IDX 3'd6
`endif

package rotate_tetromino_pkg;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned ROT_W   = 2;
  localparam int unsigned COORD_W = 5;
  localparam int unsigned CELL_W  = 4;
  localparam int unsigned BOX     = 4;

  typedef struct packed {
    logic [IDX_W-1:0] data;
  } tetromino_idx_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coordinate_t;

  // data[row][col], row 0 top, col 0 left
  typedef struct packed {
    logic [BOX-1:0][BOX-1:0][CELL_W-1:0] data;
  } tetromino_t;

  typedef struct packed {
    tetromino_idx_t   idx;
    logic [ROT_W-1:0] rotation;
    coordinate_t      coordinate;
    tetromino_t       tetromino;
  } tetromino_ctrl;
endpackage

module rotate_tetromino_unit
  import rotate_tetromino_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          clockwise,
  input  tetromino_ctrl t_in,
  output tetromino_ctrl t_out,
  output logic          success,
  output logic          done
);

  // Occupancy mask per orientation: nibble r is row r, bit c within it is col c.
  function automatic logic [15:0] shape_mask(input logic [IDX_W-1:0] idx,
                                             input logic [ROT_W-1:0] rot);
    logic [15:0] m;
    m = 16'h0000;
    case (idx)
      `TETROMINO_I_IDX: case (rot)
        2'd0: m = 16'h00F0;  2'd1: m = 16'h4444;
        2'd2: m = 16'h0F00;  default: m = 16'h2222;
      endcase
      `TETROMINO_O_IDX: m = 16'h0066;
      `TETROMINO_T_IDX: case (rot)
        2'd0: m = 16'h0072;  2'd1: m = 16'h0262;
        2'd2: m = 16'h0270;  default: m = 16'h0232;
      endcase
      `TETROMINO_S_IDX: case (rot)
        2'd0: m = 16'h0036;  2'd1: m = 16'h0462;
        2'd2: m = 16'h0360;  default: m = 16'h0231;
      endcase
      `TETROMINO_Z_IDX: case (rot)
        2'd0: m = 16'h0063;  2'd1: m = 16'h0264;
        2'd2: m = 16'h0630;  default: m = 16'h0132;
      endcase
      `TETROMINO_J_IDX: case (rot)
        2'd0: m = 16'h0071;  2'd1: m = 16'h0226;
        2'd2: m = 16'h0470;  default: m = 16'h0322;
      endcase
      `TETROMINO_L_IDX: case (rot)
        2'd0: m = 16'h0074;  2'd1: m = 16'h0622;
        2'd2: m = 16'h0170;  default: m = 16'h0223;
      endcase
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
    logic v;
    v = 1'b0;
    case (idx)
      `TETROMINO_I_IDX, `TETROMINO_O_IDX, `TETROMINO_T_IDX, `TETROMINO_S_IDX,
      `TETROMINO_Z_IDX, `TETROMINO_J_IDX, `TETROMINO_L_IDX: v = 1'b1;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  logic             valid;
  logic [ROT_W-1:0] rot_new;
  logic [15:0]      mask;
  logic [CELL_W-1:0] cell_val;
  tetromino_ctrl    rotated;

  always_comb begin
    valid    = idx_valid(t_in.idx.data);
    rot_new  = clockwise ? ROT_W'(t_in.rotation + 2'd1) : ROT_W'(t_in.rotation - 2'd1);
    mask     = shape_mask(t_in.idx.data, rot_new);
    cell_val = CELL_W'(t_in.idx.data) + CELL_W'(1);
    rotated            = t_in;
    rotated.rotation   = rot_new;
    for (int r = 0; r < BOX; r++) begin
      for (int c = 0; c < BOX; c++) begin
        rotated.tetromino.data[r][c] = mask[r*BOX + c] ? cell_val : '0;
      end
    end
  end

  // Reset wins over enable; idle edges hold t_out and drop the strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_out   <= '0;
      success <= 1'b0;
      done    <= 1'b0;
    end else if (enable) begin
      t_out   <= valid ? rotated : t_in;
      success <= valid;
      done    <= 1'b1;
    end else begin
      success <= 1'b0;
      done    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rotate_tetromino_unit.sv
// Bench for rotate_tetromino_unit: vector table, hand sequences, and random
// requests checked against a geometric rotation model built from spawn shapes.
module tb_rotate_tetromino_unit;
  import rotate_tetromino_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          clockwise;
  tetromino_ctrl t_in;
  tetromino_ctrl t_out;
  logic          success;
  logic          done;

  int checks = 0;
  int errors = 0;

  tetromino_ctrl exp_t;
  logic          exp_done;
  logic          exp_succ;

  rotate_tetromino_unit dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clockwise(clockwise),
    .t_in(t_in), .t_out(t_out), .success(success), .done(done)
  );

  always #5 clk = ~clk;

  // Spawn picture rotated 'rot' quarter turns clockwise inside its bounding box.
  function automatic tetromino_t model_cells(input int idx, input int rot);
    string pic;
    int n;
    int g[4][4];
    int h[4][4];
    tetromino_t t;
    case (idx)
      0: begin pic = "....XXXX........"; n = 4; end
      1: begin pic = ".XX..XX........."; n = 0; end
      2: begin pic = ".X..XXX........."; n = 3; end
      3: begin pic = ".XX.XX.........."; n = 3; end
      4: begin pic = "XX...XX........."; n = 3; end
      5: begin pic = "X...XXX........."; n = 3; end
      default: begin pic = "..X.XXX........."; n = 3; end
    endcase
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        g[r][c] = (pic[r*4+c] == "X") ? 1 : 0;
    if (n > 0) begin
      for (int k = 0; k < rot; k++) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            h[r][c] = (r < n && c < n) ? g[n-1-c][r] : 0;
        g = h;
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t.data[r][c] = g[r][c] != 0 ? 4'(idx + 1) : 4'd0;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one edge and advance the reference state.
  task automatic apply(input logic r, input logic e, input logic c, input tetromino_ctrl ti);
    @(negedge clk);
    rst_n = r; enable = e; clockwise = c; t_in = ti;
    if (!r) begin
      exp_t = '0; exp_done = 1'b0; exp_succ = 1'b0;
    end else if (e) begin
      exp_done = 1'b1;
      exp_t    = ti;
      if (int'(ti.idx.data) < 7) begin
        exp_succ       = 1'b1;
        exp_t.rotation = 2'((int'(ti.rotation) + (c ? 1 : 3)) % 4);
        exp_t.tetromino = model_cells(int'(ti.idx.data), int'(exp_t.rotation));
      end else begin
        exp_succ = 1'b0;
      end
    end else begin
      exp_done = 1'b0; exp_succ = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".t_out"}, 128'(t_out), 128'(exp_t));
    check({tag, ".done"}, 128'(done), 128'(exp_done));
    check({tag, ".success"}, 128'(success), 128'(exp_succ));
  endtask

  function automatic tetromino_ctrl mk(input int idx, input int rot, input int x, input int y);
    tetromino_ctrl t;
    t = '0;
    t.idx.data = 3'(idx);
    t.rotation = 2'(rot);
    t.coordinate.x = 5'(x);
    t.coordinate.y = 5'(y);
    // Garbage cells that must never leak into a rotated result.
    t.tetromino.data = {$urandom(), $urandom()};
    return t;
  endfunction

  typedef struct {
    logic r, e, c;
    int idx, rot, x, y;
    int exp_rot;
    logic exp_done, exp_succ;
  } vec_t;

  vec_t vecs[10];

  initial begin
    tetromino_t o_first;
    tetromino_ctrl t;
    int col_cnt, tot_cnt;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 2, 0, 3, 0, 1, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 2, 2, 7, 7, 1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 2, 3, 4, 5, 0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 2, 0, 4, 5, 3, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 2, 1, 4, 5, 0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 2, 0, 3, 3, 0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 7, 2, 9, 17, 2, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 5, 1, 31, 31, 2, 1'b1, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 6, 0, 1, 2, 3, 1'b1, 1'b1};

    rst_n = 1'b0; enable = 1'b0; clockwise = 1'b0; t_in = '0;
    exp_t = '0; exp_done = 1'b0; exp_succ = 1'b0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].r, vecs[i].e, vecs[i].c,
            mk(vecs[i].idx, vecs[i].rot, vecs[i].x, vecs[i].y));
      check_all($sformatf("vec%0d", i));
      check($sformatf("vec%0d.rotation", i), 128'(t_out.rotation), 128'(vecs[i].exp_rot));
      check($sformatf("vec%0d.done_tbl", i), 128'(done), 128'(vecs[i].exp_done));
      check($sformatf("vec%0d.success_tbl", i), 128'(success), 128'(vecs[i].exp_succ));
    end

    // O piece: four CW turns, shape never changes.
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 1'b1, 1'b1, mk(1, k, 4, 0));
      check_all($sformatf("o_cw%0d", k));
      check($sformatf("o_cw%0d.rot", k), 128'(t_out.rotation), 128'((k + 1) % 4));
      if (k == 0) o_first = model_cells(1, 0);
      check($sformatf("o_cw%0d.same", k), 128'(t_out.tetromino), 128'(o_first));
    end

    // I piece spawn -> rotation 1 is a single vertical column.
    apply(1'b1, 1'b1, 1'b1, mk(0, 0, 3, 1));
    check_all("i_cw");
    col_cnt = 0; tot_cnt = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (t_out.tetromino.data[r][c] != 4'd0) begin
          tot_cnt++;
          if (c == 2 && t_out.tetromino.data[r][c] == 4'd1) col_cnt++;
        end
    check("i_cw.col2", 128'(col_cnt), 128'(4));
    check("i_cw.total", 128'(tot_cnt), 128'(4));

    // Back-to-back requests, then reset released straight into a request.
    apply(1'b1, 1'b1, 1'b0, mk(3, 0, 1, 1));
    check_all("b2b0");
    apply(1'b1, 1'b1, 1'b1, mk(4, 2, 2, 2));
    check_all("b2b1");
    apply(1'b0, 1'b1, 1'b1, mk(5, 1, 6, 6));
    check_all("rst_req");
    apply(1'b1, 1'b1, 1'b1, mk(5, 1, 6, 6));
    check_all("post_rst");

    for (int i = 0; i < 300; i++) begin
      t = mk(int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
             int'($urandom_range(31, 0)), int'($urandom_range(31, 0)));
      apply(($urandom_range(15, 0) != 0), ($urandom_range(3, 0) != 0),
            1'($urandom), t);
      check_all($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
